uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Frame loader: pulls A5/LEN/data frames from a UART RX FIFO into instruction memory, answers ACK/NAK.
// Define LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module uart_prog_loader #(
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic        clk_50M,
  input  logic        Rst,
  input  logic        prog,
  input  logic        rx_data_present,
  input  logic [7:0]  uart_dout,
  input  logic        tx_full,
  output logic        rx_ren,
  output logic        tx_wen,
  output logic [7:0]  uart_din,
  output logic        imem_en,
  output logic        imem_prog_ena,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] RESP  = 3'd6;
  localparam logic [2:0] FLUSH = 3'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM       = 3'd5;
  localparam logic [2:0] AFTER_DATA = CSUM;
`else
  localparam logic [2:0] AFTER_DATA = RESP;
`endif

  logic [2:0]    state;
  logic [15:0]   len;
  logic [31:0]   word;
  logic [1:0]    byte_idx;
  logic [TW-1:0] tmr;
  logic          nak;
  logic          consume;
  logic          pop;
  logic          timed_out;
  logic [15:0]   len_rx;
  logic [15:0]   wc_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
  logic [7:0]    sum_add;
  assign sum_add = sum + uart_dout;
`endif

  always_comb begin
    consume = 1'b0;
    case (state)
      IDLE, LEN0, LEN1, DATA: consume = prog;
`ifdef LOADER_CHECKSUM_EN
      CSUM: consume = prog;
`endif
      FLUSH: consume = 1'b1;  // draining an aborted frame must not depend on prog, which is already low
      default: consume = 1'b0;
    endcase
  end

  assign pop       = !Rst && rx_data_present && consume;
  assign timed_out = !pop && (tmr <= TW'(1)) && (state != IDLE) && (state != RESP);
  assign len_rx    = {uart_dout, len[7:0]};
  assign wc_next   = word_count + 16'd1;

  assign rx_ren        = pop;
  assign tx_wen        = !Rst && (state == RESP) && !tx_full;
  assign uart_din      = tx_wen ? (nak ? NAK_BYTE : ACK_BYTE) : 8'h00;
  assign imem_en       = !Rst && (state == WRITE);
  assign imem_prog_ena = imem_en;
  assign imem_addr     = {14'd0, word_count, 2'b00};
  assign imem_din      = word;

  always_ff @(posedge clk_50M) begin
    if (Rst) begin
      state      <= IDLE;
      len        <= '0;
      word       <= '0;
      byte_idx   <= '0;
      tmr        <= '0;
      nak        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      if (pop) tmr <= TMR_LOAD;
      else if (tmr != '0) tmr <= tmr - TW'(1);

      case (state)
        IDLE: begin
          if (pop && uart_dout == SYNC_BYTE) begin
            state      <= LEN0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            nak        <= 1'b0;
            word_count <= '0;
            byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        LEN0, LEN1, DATA: begin
          if (!prog) begin
            state <= FLUSH; err <= 1'b1; nak <= 1'b1;
          end else if (timed_out) begin
            state <= RESP; err <= 1'b1; nak <= 1'b1;
          end else if (pop) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum_add;
`endif
            if (state == LEN0) begin
              len[7:0] <= uart_dout;
              state    <= LEN1;
            end else if (state == LEN1) begin
              len[15:8] <= uart_dout;
              if (len_rx == '0) state <= AFTER_DATA;
              else if ({1'b0, len_rx} > 17'(MAX_WORDS)) begin
                state <= RESP; err <= 1'b1; nak <= 1'b1;
              end else state <= DATA;
            end else begin
              word     <= {uart_dout, word[31:8]};
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) state <= WRITE;
            end
          end
        end
        WRITE: begin
          // the strobe is already on the bus this cycle, so the word counts even if we abort now
          word_count <= wc_next;
          if (!prog) begin
            state <= FLUSH; err <= 1'b1; nak <= 1'b1;
          end else if (timed_out) begin
            state <= RESP; err <= 1'b1; nak <= 1'b1;
          end else if (wc_next == len) state <= AFTER_DATA;
          else state <= DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (!prog) begin
            state <= FLUSH; err <= 1'b1; nak <= 1'b1;
          end else if (timed_out) begin
            state <= RESP; err <= 1'b1; nak <= 1'b1;
          end else if (pop) begin
            state <= RESP;
            if (sum_add != 8'h00) begin
              err <= 1'b1; nak <= 1'b1;
            end
          end
        end
`endif
        RESP: begin
          if (!tx_full) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= !nak;
          end
        end
        FLUSH: begin
          if (!pop) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: FIFO model, write/TX loggers and a frame-level reference model.
// Honours LOADER_CHECKSUM_EN when building frames and predicting the response.
module tb_uart_prog_loader;
  localparam int MAX_W = 1024;
  localparam int TMO   = 100;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  typedef logic [7:0] bq_t[$];

  logic        clk_50M = 1'b0;
  logic        Rst;
  logic        prog;
  logic        rx_data_present;
  logic [7:0]  uart_dout;
  logic        tx_full;
  logic        rx_ren;
  logic        tx_wen;
  logic [7:0]  uart_din;
  logic        imem_en;
  logic        imem_prog_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  always #10 clk_50M = ~clk_50M;

  uart_prog_loader #(.MAX_WORDS(MAX_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_50M(clk_50M), .Rst(Rst), .prog(prog), .rx_data_present(rx_data_present),
    .uart_dout(uart_dout), .tx_full(tx_full), .rx_ren(rx_ren), .tx_wen(tx_wen),
    .uart_din(uart_din), .imem_en(imem_en), .imem_prog_ena(imem_prog_ena),
    .imem_addr(imem_addr), .imem_din(imem_din), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int tx_cyc = 0;
  int ren_viol = 0;
  int wen_viol = 0;
  int en_viol = 0;
  logic [7:0]  rx_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_words[$];
  logic [7:0]  tx_log[$];

  // RX FIFO model plus loggers: observe mid-cycle, retire the popped byte just after the edge
  initial begin
    bit pend;
    rx_data_present = 1'b0;
    uart_dout = 8'h00;
    forever begin
      @(negedge clk_50M);
      cyc++;
      pend = rx_ren;
      if (rx_ren && !rx_data_present) ren_viol++;
      if (rx_ren) last_pop_cyc = cyc;
      if (imem_prog_ena) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_din);
        if (!imem_en) en_viol++;
      end
      if (tx_wen) begin
        tx_log.push_back(uart_din);
        tx_cyc = cyc;
        if (tx_full) wen_viol++;
      end
      @(posedge clk_50M);
      #1;
      if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_data_present = rx_q.size() > 0;
      uart_dout = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_bytes(input bq_t b, input int max_gap);
    foreach (b[i]) begin
      rx_q.push_back(b[i]);
      for (int t = 0; t < 50 && rx_q.size() != 0; t++) @(negedge clk_50M);
      repeat ($urandom_range(max_gap, 0)) @(negedge clk_50M);
    end
  endtask

  task automatic wait_tx(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk_50M);
      if (tx_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    tick(2);
  endtask

  function automatic bq_t add_csum(input bq_t f, input bit ok);
    bq_t r;
    logic [7:0] s;
    r = f;
    s = 8'h00;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    if (CSUM_EN) r.push_back(ok ? 8'(0 - s) : 8'(0 - s) ^ 8'h5A);
    return r;
  endfunction

  function automatic bq_t make_frame(input int len, input bit csum_ok);
    bq_t f;
    f.push_back(8'hA5);
    f.push_back(8'(len));
    f.push_back(8'(len >> 8));
    if (len > MAX_W) return f;
    for (int i = 0; i < 4 * len; i++) f.push_back(8'($urandom));
    return add_csum(f, csum_ok);
  endfunction

  // Reference: decode a complete frame by the protocol rules; fills exp_words, returns ACK/NAK.
  function automatic bit model_frame(input bq_t f);
    int len;
    int s;
    exp_words.delete();
    len = int'(f[1]) + 256 * int'(f[2]);
    if (len > MAX_W) return 1'b0;
    for (int k = 0; k < len; k++)
      exp_words.push_back({f[6+4*k], f[5+4*k], f[4+4*k], f[3+4*k]});
    if (!CSUM_EN) return 1'b1;
    s = 0;
    for (int i = 1; i < f.size(); i++) s += int'(f[i]);
    return (s % 256) == 0;
  endfunction

  task automatic test_reset();
    logic [120:0] outs;
    Rst = 1'b1; prog = 1'b1; tx_full = 1'b0;
    rx_q.push_back(8'hA5);
    tick(3);
    checks++;
    if (rx_ren !== 1'b0) begin
      failures++; $display("FAIL reset_rx_ren: got %0b expected 0", rx_ren);
    end
    outs = {tx_wen, uart_din, imem_en, imem_prog_ena, imem_addr, imem_din, busy, done, err, word_count};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    Rst = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL sync_sets_busy: got %0b expected 1", busy);
    end
    Rst = 1'b1;
    rx_q.delete();
    tick(2);
    Rst = 1'b0;
    tick(2);
  endtask

  task automatic test_example();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
    f = add_csum(f, 1'b1);
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 2);
    wait_tx(n0, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL example_tx_timeout: got no TX expected 06"); end
    checks++;
    if (wr_data_q.size() != 2) begin
      failures++; $display("FAIL example_write_count: got %0d expected 2", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h00000013) begin
        failures++; $display("FAIL example_write0: got %0h/%0h expected 0/13", wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h000010B7) begin
        failures++; $display("FAIL example_write1: got %0h/%0h expected 4/10b7", wr_addr_q[1], wr_data_q[1]);
      end
    end
    if (ok) begin
      checks++;
      if (tx_log[n0] !== 8'h06) begin failures++; $display("FAIL example_tx: got %0h expected 06", tx_log[n0]); end
    end
    checks++;
    if ({done, err, busy, word_count} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
      failures++; $display("FAIL example_status: got done=%0b err=%0b busy=%0b wc=%0d expected 1 0 0 2",
                           done, err, busy, word_count);
    end
  endtask

  task automatic test_empty_frame();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h00, 8'h00};
    f = add_csum(f, 1'b1);
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 1);
    wait_tx(n0, 100, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h06) begin failures++; $display("FAIL empty_tx: got ok=%0b expected ACK 06", ok); end
    checks++;
    if (wr_data_q.size() != 0 || done !== 1'b1) begin
      failures++; $display("FAIL empty_status: got writes=%0d done=%0b expected 0 1", wr_data_q.size(), done);
    end
  endtask

  task automatic test_too_long();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h01, 8'h04};
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 1);
    wait_tx(n0, 100, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h15) begin failures++; $display("FAIL too_long_tx: got ok=%0b expected NAK 15", ok); end
    checks++;
    if (wr_data_q.size() != 0 || err !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL too_long_status: got writes=%0d err=%0b done=%0b expected 0 1 0",
                           wr_data_q.size(), err, done);
    end
  endtask

  task automatic test_max_len();
    bq_t f;
    bit ok;
    bit ack;
    int n0;
    f = make_frame(MAX_W, 1'b1);
    ack = model_frame(f);
    clear_logs();
    n0 = tx_log.size();
    foreach (f[i]) rx_q.push_back(f[i]);
    wait_tx(n0, 12000, ok);
    checks++;
    if (!ok || tx_log[n0] !== (ack ? 8'h06 : 8'h15)) begin
      failures++; $display("FAIL max_len_tx: got ok=%0b expected response %0b", ok, ack);
    end
    checks++;
    if (wr_data_q.size() != exp_words.size()) begin
      failures++; $display("FAIL max_len_count: got %0d expected %0d", wr_data_q.size(), exp_words.size());
    end else begin
      foreach (exp_words[k]) begin
        checks++;
        if (wr_data_q[k] !== exp_words[k] || wr_addr_q[k] !== 32'(4 * k)) begin
          failures++; $display("FAIL max_len_word%0d: got %0h@%0h expected %0h@%0h",
                               k, wr_data_q[k], wr_addr_q[k], exp_words[k], 4 * k);
        end
      end
    end
    checks++;
    if (word_count !== 16'(MAX_W)) begin failures++; $display("FAIL max_len_wc: got %0d expected %0d", word_count, MAX_W); end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 12; n++) begin
      bq_t f;
      bq_t g;
      bq_t head;
      bq_t rest;
      bit ok;
      bit ack;
      int n0;
      int r;
      int len;
      logic [7:0] gb;
      r = $urandom_range(9, 0);
      len = (r == 0) ? $urandom_range(65535, MAX_W + 1) : $urandom_range(6, 0);
      f = make_frame(len, r != 1);
      ack = model_frame(f);
      repeat ($urandom_range(3, 0)) begin
        do gb = 8'($urandom); while (gb == 8'hA5);
        g.push_back(gb);
      end
      head = {f[0]};
      rest = f[1:$];
      clear_logs();
      n0 = tx_log.size();
      send_bytes(g, 1);
      send_bytes(head, 0);
      checks++;
      if ({busy, done, err, word_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
        failures++; $display("FAIL rand%0d_start: got busy=%0b done=%0b err=%0b wc=%0d expected 1 0 0 0",
                             n, busy, done, err, word_count);
      end
      send_bytes(rest, 3);
      wait_tx(n0, 300, ok);
      checks++;
      if (!ok || tx_log[n0] !== (ack ? 8'h06 : 8'h15)) begin
        failures++; $display("FAIL rand%0d_tx: got ok=%0b expected ack=%0b", n, ok, ack);
      end
      checks++;
      if (wr_data_q.size() != exp_words.size()) begin
        failures++; $display("FAIL rand%0d_count: got %0d expected %0d", n, wr_data_q.size(), exp_words.size());
      end else begin
        foreach (exp_words[k]) begin
          checks++;
          if (wr_data_q[k] !== exp_words[k] || wr_addr_q[k] !== 32'(4 * k)) begin
            failures++; $display("FAIL rand%0d_word%0d: got %0h@%0h expected %0h@%0h",
                                 n, k, wr_data_q[k], wr_addr_q[k], exp_words[k], 4 * k);
          end
        end
      end
      checks++;
      if ({done, err, busy, word_count} !== {ack, !ack, 1'b0, 16'(exp_words.size())}) begin
        failures++; $display("FAIL rand%0d_status: got done=%0b err=%0b busy=%0b wc=%0d expected %0b %0b 0 %0d",
                             n, done, err, busy, word_count, ack, !ack, exp_words.size());
      end
    end
  endtask

  task automatic test_timeout();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 2);
    wait_tx(n0, 300, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h15) begin failures++; $display("FAIL timeout_tx: got ok=%0b expected NAK 15", ok); end
    checks++;
    if (tx_cyc - last_pop_cyc != TMO) begin
      failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d", tx_cyc - last_pop_cyc, TMO);
    end
    checks++;
    if (err !== 1'b1 || wr_data_q.size() != 0) begin
      failures++; $display("FAIL timeout_status: got err=%0b writes=%0d expected 1 0", err, wr_data_q.size());
    end
  endtask

  task automatic test_tx_full();
    bq_t f;
    bit ok;
    int n0;
    int held;
    f = {8'hA5, 8'h00, 8'h00};
    f = add_csum(f, 1'b1);
    n0 = tx_log.size();
    tx_full = 1'b1;
    send_bytes(f, 1);
    held = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_50M);
      if (tx_wen === 1'b0 && busy === 1'b1) held++;
    end
    checks++;
    if (held != 20 || tx_log.size() != n0) begin
      failures++; $display("FAIL txfull_hold: got %0d quiet cycles, %0d tx expected 20, 0", held, tx_log.size() - n0);
    end
    tx_full = 1'b0;
    wait_tx(n0, 20, ok);
    tick(5);
    checks++;
    if (!ok || tx_log.size() != n0 + 1 || tx_log[n0] !== 8'h06) begin
      failures++; $display("FAIL txfull_release: got %0d tx expected exactly one ACK", tx_log.size() - n0);
    end
  endtask

  task automatic test_prog_abort();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h03, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 1);
    for (int t = 0; t < 20 && wr_data_q.size() == 0; t++) @(negedge clk_50M);
    @(negedge clk_50M);
    prog = 1'b0;
    for (int i = 0; i < 5; i++) rx_q.push_back(8'(8'h30 + i));
    wait_tx(n0, 100, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h15) begin failures++; $display("FAIL abort_tx: got ok=%0b expected NAK 15", ok); end
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h12345678) begin
      failures++; $display("FAIL abort_writes: got %0d writes expected 1 of 12345678", wr_data_q.size());
    end
    checks++;
    if (rx_q.size() != 0 || err !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL abort_flush: got left=%0d err=%0b done=%0b expected 0 1 0", rx_q.size(), err, done);
    end
    prog = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_frame();
    bq_t f;
    bit ok;
    bit ack;
    int n0;
    f = {8'hA5, 8'h03, 8'h00, 8'h11, 8'h22};
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 1);
    Rst = 1'b1;
    tick(2);
    rx_q.delete();
    tick(1);
    Rst = 1'b0;
    tick(3);
    checks++;
    if (tx_log.size() != n0 || busy !== 1'b0 || word_count !== 16'd0) begin
      failures++; $display("FAIL rst_mid_abort: got tx=%0d busy=%0b wc=%0d expected 0 0 0",
                           tx_log.size() - n0, busy, word_count);
    end
    f = make_frame(1, 1'b1);
    ack = model_frame(f);
    send_bytes(f, 2);
    wait_tx(n0, 200, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h06 || wr_data_q.size() != 1 || wr_data_q[0] !== exp_words[0]) begin
      failures++; $display("FAIL rst_mid_next: got ok=%0b writes=%0d expected ACK=%0b with 1 write", ok,
                           wr_data_q.size(), ack);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    bq_t f;
    bit ok;
    int n0;
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
    f = add_csum(f, 1'b0);
    clear_logs();
    n0 = tx_log.size();
    send_bytes(f, 1);
    wait_tx(n0, 200, ok);
    checks++;
    if (!ok || tx_log[n0] !== 8'h15) begin failures++; $display("FAIL bad_csum_tx: got ok=%0b expected NAK 15", ok); end
    checks++;
    if (wr_data_q.size() != 2 || err !== 1'b1) begin
      failures++; $display("FAIL bad_csum_status: got writes=%0d err=%0b expected 2 1", wr_data_q.size(), err);
    end
  endtask
`endif

  task automatic test_strobe_rules();
    checks++;
    if (ren_viol != 0) begin failures++; $display("FAIL ren_without_data: got %0d expected 0", ren_viol); end
    checks++;
    if (wen_viol != 0) begin failures++; $display("FAIL wen_while_full: got %0d expected 0", wen_viol); end
    checks++;
    if (en_viol != 0) begin failures++; $display("FAIL prog_ena_without_en: got %0d expected 0", en_viol); end
  endtask

  initial begin
    test_reset();
    test_example();
    test_empty_frame();
    test_too_long();
    test_timeout();
    test_tx_full();
    test_random_frames();
    test_prog_abort();
    test_reset_mid_frame();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_max_len();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
